// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter with internal line buffers; output 3 enabled cycles after pixel accept.
// Backpressure: the whole pipeline stalls while an output is held, in_ready = !out_valid || out_ready.
module sobel_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int SHIFT = 2
) (
    input  logic             ck,
    input  logic             res_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] thresh,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_eol
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = PIX_W + 4;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic             mode;
        logic [PIX_W-1:0] thr;
    } meta_t;

    logic en;
    logic acc;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && res_n;
    assign acc      = in_valid && in_ready;

    // ---------------- position tracking and frame-control shadows
    logic [CW-1:0]    col, col_eff;
    logic [RW-1:0]    row, row_eff;
    logic [PIX_W-1:0] thr_sh, thr_cur;
    logic             mode_sh, mode_cur;

    always_comb begin
        col_eff  = in_sof ? '0 : col;
        row_eff  = in_sof ? '0 : row;
        thr_cur  = in_sof ? thresh : thr_sh;
        mode_cur = in_sof ? mode : mode_sh;
    end

    always_ff @(posedge ck) begin
        if (!res_n) begin
            col     <= '0;
            row     <= '0;
            thr_sh  <= '0;
            mode_sh <= 1'b0;
        end else if (acc) begin
            if (in_sof) begin
                thr_sh  <= thresh;
                mode_sh <= mode;
            end
            if (col_eff == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + 1'b1;
            end else begin
                col <= col_eff + 1'b1;
                row <= row_eff;
            end
        end
    end

    // ---------------- stage 0: registered accepted pixel with its position-derived tags
    logic             p0_vld;
    logic [PIX_W-1:0] p0_pix;
    logic [CW-1:0]    p0_col;
    logic             p0_emit;
    meta_t            p0_meta;

    always_ff @(posedge ck) begin
        if (!res_n) begin
            p0_vld <= 1'b0;
        end else if (en) begin
            p0_vld <= acc;
        end
    end

    always_ff @(posedge ck) begin
        if (acc) begin
            p0_pix       <= in_pix;
            p0_col       <= col_eff;
            p0_emit      <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            p0_meta.sof  <= (row_eff == RW'(2)) && (col_eff == CW'(2));
            p0_meta.eol  <= (col_eff == CW'(IMG_W - 1));
            p0_meta.mode <= mode_cur;
            p0_meta.thr  <= thr_cur;
        end
    end

    // ---------------- stage 1: line buffers and 3x3 window, win[row][col], row 0 oldest line
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] win [3][3];
    logic             s1_vld;
    meta_t            s1_meta;

    always_ff @(posedge ck) begin
        if (en && p0_vld) begin
            lb2[p0_col] <= lb1[p0_col];
            lb1[p0_col] <= p0_pix;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2[p0_col];
            win[1][2] <= lb1[p0_col];
            win[2][2] <= p0_pix;
        end
    end

    always_ff @(posedge ck) begin
        if (!res_n) begin
            s1_vld <= 1'b0;
        end else if (en) begin
            s1_vld <= p0_vld && p0_emit;
        end
    end

    always_ff @(posedge ck) begin
        if (en) begin
            s1_meta <= p0_meta;
        end
    end

    // ---------------- stage 2: gradients
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    logic signed [GW-1:0] gx, gy;
    logic signed [GW-1:0] s2_gx, s2_gy;
    logic                 s2_vld;
    meta_t                s2_meta;

    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    end

    always_ff @(posedge ck) begin
        if (!res_n) begin
            s2_vld <= 1'b0;
        end else if (en) begin
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge ck) begin
        if (en) begin
            s2_gx   <= gx;
            s2_gy   <= gy;
            s2_meta <= s1_meta;
        end
    end

    // ---------------- stage 3: magnitude, scaling and output formatting
    logic [GW-1:0]    ax, ay, g, gs;
    logic [PIX_W-1:0] res;

    always_comb begin
        ax = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
        ay = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
        g  = ax + ay;
        gs = g >> SHIFT;
        if (s2_meta.mode) begin
            res = (|gs[GW-1:PIX_W]) ? '1 : gs[PIX_W-1:0];
        end else begin
            res = (gs > {4'b0000, s2_meta.thr}) ? '1 : '0;
        end
    end

    always_ff @(posedge ck) begin
        if (!res_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_vld;
            out_sof   <= s2_vld && s2_meta.sof;
            out_eol   <= s2_vld && s2_meta.eol;
            if (s2_vld) begin
                out_pix <= res;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x6 image; two instances differ only in SHIFT (2 and 0).
module tb_sobel_stream_filter;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    localparam int PA = 0;  // cols 0-3 = 0, cols 4-7 = 200
    localparam int PB = 1;  // col 0 = 0, rest 255
    localparam int PC = 2;  // cols 0-3 = 0, cols 4-7 = 100
    localparam int PD = 3;  // cols 0-3 = 200, cols 4-7 = 0
    localparam int PH = 4;  // rows 0-2 = 0, rows 3-5 = 200
    localparam int PU = 5;  // uniform 255

    logic       ck = 1'b0;
    logic       res_n, in_valid, in_sof, mode, out_ready;
    logic [7:0] in_pix, thresh;
    logic       in_ready, in_ready0;
    logic       out_valid, out_valid0, out_sof, out_sof0, out_eol, out_eol0;
    logic [7:0] out_pix, out_pix0;

    always #5 ck = ~ck;

    sobel_stream_filter #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .SHIFT(2)) dut (
        .ck(ck), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .in_sof(in_sof), .thresh(thresh), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_pix(out_pix), .out_sof(out_sof), .out_eol(out_eol)
    );

    sobel_stream_filter #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (
        .ck(ck), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready0), .in_pix(in_pix),
        .in_sof(in_sof), .thresh(thresh), .mode(mode), .out_valid(out_valid0),
        .out_ready(out_ready), .out_pix(out_pix0), .out_sof(out_sof0), .out_eol(out_eol0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_to  = 0;
    int first_vld = -1;
    bit arm_lat   = 1'b0;

    logic [7:0] q_pix[$];
    logic [8:0] q_pix0[$];
    logic       q_sof[$];
    logic       q_eol[$];

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        if (res_n && out_valid && out_ready) begin
            q_pix.push_back(out_pix);
            q_pix0.push_back({out_valid0, out_pix0});
            q_sof.push_back(out_sof);
            q_eol.push_back(out_eol);
        end
        if (arm_lat && out_valid && first_vld < 0) first_vld = cyc;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
        case (pat)
            PA:      return (c >= 4) ? 8'd200 : 8'd0;
            PB:      return (c == 0) ? 8'd0 : 8'd255;
            PC:      return (c >= 4) ? 8'd100 : 8'd0;
            PD:      return (c >= 4) ? 8'd0 : 8'd200;
            PH:      return (r >= 3) ? 8'd200 : 8'd0;
            default: return 8'd255;
        endcase
    endfunction

    function automatic bit is_edge(input int pat, input int r, input int c);
        case (pat)
            PA, PC, PD: return (c == 3) || (c == 4);
            PB:         return (c == 1);
            PH:         return (r == 2) || (r == 3);
            default:    return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input int pat, input logic m, input logic [7:0] th, input logic sof,
                              input int npix, input bit bubbles, output int acc_c);
        bit ok;
        acc_c  = -1;
        thresh = th;
        mode   = m;
        for (int idx = 0; idx < npix; idx++) begin
            if (bubbles && (idx % 5 == 3)) begin
                in_valid = 1'b0;
                @(posedge ck); #1;
            end
            in_valid = 1'b1;
            in_pix   = pix_of(pat, idx / W, idx % W);
            in_sof   = sof && (idx == 0);
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge ck);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_to++;
                in_valid = 1'b0;
                in_sof   = 1'b0;
                return;
            end
            @(posedge ck); #1;
            if (idx == 2 * W + 2) acc_c = cyc;
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (12) @(posedge ck);
        #1;
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_pix0.delete();
        q_sof.delete();
        q_eol.delete();
    endtask

    task automatic check_frame(input string tag, input int pat, input logic [7:0] e2, input logic [7:0] e0);
        int r, c;
        bit ed;
        chk($sformatf("%s count", tag), q_pix.size(), NOUT);
        for (int i = 0; i < q_pix.size() && i < NOUT; i++) begin
            r  = 1 + i / (W - 2);
            c  = 1 + i % (W - 2);
            ed = is_edge(pat, r, c);
            chk($sformatf("%s[%0d,%0d] pix_s2", tag, r, c), q_pix[i], ed ? e2 : 8'd0);
            chk($sformatf("%s[%0d,%0d] pix_s0", tag, r, c), q_pix0[i], {1'b1, ed ? e0 : 8'd0});
            chk($sformatf("%s[%0d,%0d] sof", tag, r, c), q_sof[i], (i == 0));
            chk($sformatf("%s[%0d,%0d] eol", tag, r, c), q_eol[i], (c == W - 2));
        end
        clear_q();
    endtask

    task automatic stall_seq();
        bit         found;
        logic [7:0] snap, snap0;
        found = 1'b0;
        repeat (20) @(posedge ck);
        for (int k = 0; k < 300; k++) begin
            @(posedge ck); #1;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall found_valid", found, 1);
        if (found) begin
            snap      = out_pix;
            snap0     = out_pix0;
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
                @(negedge ck);
                chk($sformatf("stall[%0d] in_ready", s), in_ready, 0);
                chk($sformatf("stall[%0d] out_valid", s), out_valid, 1);
                chk($sformatf("stall[%0d] out_pix", s), out_pix, snap);
                chk($sformatf("stall[%0d] out_pix_s0", s), out_pix0, snap0);
            end
            @(posedge ck); #1;
            out_ready = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_pix"}, out_pix, 0);
        chk({tag, " out_sof"}, out_sof, 0);
        chk({tag, " out_eol"}, out_eol, 0);
    endtask

    typedef struct {
        int         pat;
        logic       m;
        logic [7:0] th;
        logic       sof;
        logic [7:0] e2;
        logic [7:0] e0;
        string      tag;
    } vec_t;

    vec_t vt[10];
    int   acc18, dummy;

    initial begin
        // edge-centre value for SHIFT=2 (e2) and SHIFT=0 (e0); all other centres are 0
        vt[0] = '{PA, 1'b0, 8'd25,  1'b1, 8'hFF, 8'hFF, "a_bin25"};
        vt[1] = '{PA, 1'b1, 8'd25,  1'b1, 8'd200, 8'd255, "a_mag"};
        vt[2] = '{PU, 1'b1, 8'd0,   1'b1, 8'd0,  8'd0,   "u_mag"};
        vt[3] = '{PB, 1'b1, 8'd0,   1'b1, 8'd255, 8'd255, "b_mag"};
        vt[4] = '{PC, 1'b1, 8'd0,   1'b1, 8'd100, 8'd255, "c_mag"};
        vt[5] = '{PC, 1'b0, 8'd100, 1'b1, 8'd0,  8'hFF, "c_bin100"};
        vt[6] = '{PC, 1'b0, 8'd99,  1'b1, 8'hFF, 8'hFF, "c_bin99"};
        vt[7] = '{PD, 1'b1, 8'd0,   1'b1, 8'd200, 8'd255, "d_mag"};
        vt[8] = '{PH, 1'b1, 8'd0,   1'b1, 8'd200, 8'd255, "h_mag"};
        vt[9] = '{PH, 1'b0, 8'd7,   1'b0, 8'd200, 8'd255, "h_wrap"};

        res_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
        thresh = '0; mode = 1'b0; out_ready = 1'b1;

        repeat (3) @(posedge ck);
        @(negedge ck);
        check_reset_outputs("reset");
        @(posedge ck); #1;
        res_n = 1'b1;
        @(negedge ck);
        chk("reset release in_ready", in_ready, 1);
        @(posedge ck); #1;

        for (int i = 0; i < 10; i++) begin
            send_frame(vt[i].pat, vt[i].m, vt[i].th, vt[i].sof, W * H, 1'b1, dummy);
            drain();
            check_frame(vt[i].tag, vt[i].pat, vt[i].e2, vt[i].e0);
        end

        first_vld = -1;
        arm_lat   = 1'b1;
        send_frame(PA, 1'b1, 8'd0, 1'b1, W * H, 1'b0, acc18);
        drain();
        arm_lat = 1'b0;
        chk("latency", first_vld - acc18, 3);
        check_frame("lat", PA, 8'd200, 8'd255);

        fork
            send_frame(PA, 1'b0, 8'd25, 1'b1, W * H, 1'b1, dummy);
            stall_seq();
        join
        drain();
        check_frame("stall", PA, 8'hFF, 8'hFF);

        send_frame(PA, 1'b0, 8'd25, 1'b1, 30, 1'b1, dummy);
        res_n = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        check_reset_outputs("midreset");
        @(posedge ck); #1;
        res_n = 1'b1;
        clear_q();
        send_frame(PA, 1'b1, 8'd0, 1'b1, W * H, 1'b1, dummy);
        drain();
        check_frame("after_reset", PA, 8'd200, 8'd255);

        send_frame(PU, 1'b1, 8'd0, 1'b1, 12, 1'b1, dummy);
        send_frame(PA, 1'b0, 8'd150, 1'b1, W * H, 1'b1, dummy);
        drain();
        check_frame("sof_a150", PA, 8'hFF, 8'hFF);
        send_frame(PC, 1'b0, 8'd150, 1'b1, W * H, 1'b1, dummy);
        drain();
        check_frame("sof_c150", PC, 8'd0, 8'hFF);

        chk("accept timeouts", n_to, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
Streaming 3x3 Sobel edge detector for raster-order video, with a parametrised pixel width and image geometry. Internal line buffers build the 3x3 window, so upstream delivers one pixel per transfer and no longer presents all nine neighbours. Valid/ready handshakes on input and output. Runtime-selectable binary-threshold or scaled-magnitude output. Sits between the pixel source (camera/frame reader) and downstream frame writer.

Parameters:
PIX_W, 8, pixel bit width (input and output).
IMG_W, 640, pixels per line; >= 3.
IMG_H, 480, lines per frame; >= 3.
SHIFT, 2, right-shift applied to |GX|+|GY| before threshold/saturation.

Ports:
CK  in  1  clock, rising edge.
RES_N  in  1  synchronous active-low reset.
IN_VALID  in  1  input pixel valid.
IN_READY  out  1  block accepts pixel this cycle.
IN_PIX  in  PIX_W  unsigned input pixel.
IN_SOF  in  1  pixel is row 0, col 0 of a frame.
THRESH  in  PIX_W  edge threshold; sampled on SOF.
MODE  in  1  0 = binary (all-ones/zero), 1 = scaled magnitude; sampled on SOF.
OUT_VALID  out  1  output pixel valid.
OUT_READY  in  1  downstream accepts.
OUT_PIX  out  PIX_W  edge result.
OUT_SOF  out  1  first output pixel of frame.
OUT_EOL  out  1  last output pixel of an output line.

Behaviour:
- Reset (RES_N low at CK edge): OUT_VALID, OUT_PIX, OUT_SOF, OUT_EOL = 0; IN_READY = 0 during reset, 1 on first cycle after reset released; row/col counters = 0; pipeline valids cleared; THRESH/MODE shadows = 0. Line-buffer RAM is not cleared. Reset mid-frame discards frame in flight; the next accepted pixel is treated as (0,0).
- Transfer: input accepted when IN_VALID && IN_READY; output consumed when OUT_VALID && OUT_READY.
- Pipeline enable EN = !OUT_VALID || OUT_READY; IN_READY = EN. All stages advance together on EN; nothing advances while EN = 0. OUT_* are held stable while OUT_VALID && !OUT_READY.
- Position counters col (0..IMG_W-1), row (0..IMG_H-1) advance per accepted pixel; col wraps to 0 and increments row; row wraps after (IMG_H-1, IMG_W-1).
- IN_SOF on an accepted pixel forces that pixel to (0,0) regardless of counters, abandons any partial frame, and latches THRESH/MODE into shadows. A pixel arriving at (0,0) by wrap without IN_SOF is accepted as a new frame start; shadows keep their previous values.
- Two line buffers of IMG_W x PIX_W hold rows r-1 and r-2; together with a 3-column shift window they form a 3x3 window centred on (r-1, c-1).
- Output emitted only for interior centres: an accepted pixel at row >= 2 and col >= 2 produces one output; frame yields (IMG_W-2)*(IMG_H-2) outputs. Border pixels produce no output.
- Stage 1: window capture. Stage 2: GX = (S02+2*S12+S22)-(S00+2*S10+S20), GY = (S20+2*S21+S22)-(S00+2*S01+S02), signed PIX_W+4 bits, no overflow. Stage 3: G = |GX|+|GY| (PIX_W+3 bits unsigned), Gs = G >> SHIFT; MODE0: OUT_PIX = (Gs > THRESH) ? all ones : 0 (strictly greater); MODE1: OUT_PIX = min(Gs, 2^PIX_W-1).
- Latency: OUT_VALID asserts 3 enabled cycles after the accepting edge of the triggering pixel.
- OUT_SOF = 1 with the output for centre (1,1); OUT_EOL = 1 with the output for centre col IMG_W-2; both 0 otherwise.
- Input bubbles (IN_VALID low) insert gaps; no stall or state change results.

Test Plan:
- IMG_W=8, IMG_H=6, MODE0, THRESH=25: cols 0-3 = 0, cols 4-7 = 200 -> 24 outputs; centre cols 3,4 = 0xFF (G=800, Gs=200), all others 0x00; OUT_SOF on 1st output, OUT_EOL on every 6th.
- Same image, MODE1 -> centre cols 3,4 = 200, others 0. Uniform 255 frame -> all 24 outputs 0.
- SHIFT=0, MODE1, col 0 = 0, rest 255 -> centre col 1 = 255 (saturated from G=1020), others 0.
- Hold OUT_READY low 5 cycles mid-frame -> IN_READY low, OUT_PIX/OUT_VALID stable, no loss/duplication; output sequence identical to no-stall run; OUT_VALID rises 3 cycles after accepting pixel (2,2) with continuous input.
- Assert RES_N low mid-frame, then send full frame with IN_SOF -> exactly 24 correct outputs, no stale outputs; IN_SOF mid-frame with THRESH=150 -> frame restarts, old partial frame discarded, new threshold applied (Gs=200 still 0xFF; Gs=100 image gives 0x00).
